// File: rtl/io_bist_harness.sv
// On-chip stimulus/response harness: LFSR drives the user design, MISR compacts its response.
// Optional golden-signature comparator with pass flag when GOLDEN_CHECK_EN is defined.
module io_bist_harness #(
   parameter int                DATA_W     = 8,
   parameter int                RESP_W     = 16,
   parameter int                CNT_W      = 16,
   parameter logic [DATA_W-1:0] LFSR_TAPS  = 8'h1D,
   parameter logic [RESP_W-1:0] MISR_TAPS  = 16'h1021,
   parameter logic [DATA_W-1:0] SEED       = 8'h01,
   parameter int                SETTLE_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  vec_count,
   input  logic [RESP_W-1:0] resp_in,
`ifdef GOLDEN_CHECK_EN
   input  logic [RESP_W-1:0] golden,
   output logic              pass,
`endif
   output logic [DATA_W-1:0] stim_out,
   output logic              busy,
   output logic              done,
   output logic [RESP_W-1:0] signature
);

   localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
   localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYC);

   typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, FINISH} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] lfsr, lfsr_nxt;
   logic [RESP_W-1:0] misr, misr_nxt;
   logic [CNT_W-1:0]  remaining, remaining_nxt;
   logic [SW-1:0]     settle, settle_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lfsr      <= SEED;
         misr      <= '0;
         remaining <= '0;
         settle    <= '0;
      end else begin
         state     <= state_nxt;
         lfsr      <= lfsr_nxt;
         misr      <= misr_nxt;
         remaining <= remaining_nxt;
         settle    <= settle_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      lfsr_nxt      = lfsr;
      misr_nxt      = misr;
      remaining_nxt = remaining;
      settle_nxt    = settle;
      case (state)
         IDLE: begin
            if (start) begin
               lfsr_nxt = SEED;
               misr_nxt = '0;
               if (vec_count != '0) begin
                  remaining_nxt = vec_count;
                  settle_nxt    = SETTLE_INIT;
                  state_nxt     = (SETTLE_CYC == 0) ? CAPTURE : WAIT;
               end else begin
                  state_nxt = FINISH;
               end
            end
         end
         WAIT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (settle <= SW'(1)) begin
               state_nxt = CAPTURE;
            end else begin
               settle_nxt = settle - SW'(1);
            end
         end
         CAPTURE: begin
            // abort wins over the capture so lfsr/misr stay frozen
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               misr_nxt = {misr[RESP_W-2:0], 1'b0}
                        ^ (misr[RESP_W-1] ? MISR_TAPS : '0)
                        ^ resp_in;
               lfsr_nxt = {lfsr[DATA_W-2:0], 1'b0}
                        ^ (lfsr[DATA_W-1] ? LFSR_TAPS : '0);
               remaining_nxt = remaining - CNT_W'(1);
               if (remaining == CNT_W'(1)) begin
                  state_nxt = FINISH;
               end else begin
                  settle_nxt = SETTLE_INIT;
                  state_nxt  = (SETTLE_CYC == 0) ? CAPTURE : WAIT;
               end
            end
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef GOLDEN_CHECK_EN
   // Entering FINISH also covers a zero-length run accepted straight from IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         pass <= 1'b0;
      end else if (state_nxt == FINISH) begin
         pass <= (misr_nxt == golden);
      end else if (state == IDLE && start) begin
         pass <= 1'b0;
      end
   end
`endif

   assign stim_out  = lfsr;
   assign signature = misr;
   assign busy      = (state == WAIT) || (state == CAPTURE);
   assign done      = (state == FINISH);

endmodule

// File: tb/tb_io_bist_harness.sv
// Directed bench for io_bist_harness with default parameters (SETTLE_CYC=1).
// Golden-compare steps are built only when GOLDEN_CHECK_EN is defined.
module tb_io_bist_harness;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] vec_count = '0;
   logic [15:0] resp_in = '0;
   logic [7:0]  stim_out;
   logic        busy;
   logic        done;
   logic [15:0] signature;
`ifdef GOLDEN_CHECK_EN
   logic [15:0] golden = '0;
   logic        pass;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   io_bist_harness dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .vec_count (vec_count),
      .resp_in   (resp_in),
`ifdef GOLDEN_CHECK_EN
      .golden    (golden),
      .pass      (pass),
`endif
      .stim_out  (stim_out),
      .busy      (busy),
      .done      (done),
      .signature (signature)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [15:0] n);
      vec_count = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // cyc = 1 in the window right after the start edge
   task automatic wait_done(input int budget, output int cyc);
      cyc = 1;
      while (done !== 1'b1 && cyc < budget) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int pulses;
      logic [7:0] walk [9];
      walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};

      // reset and idle
      tick(); tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("rst_stim", 32'(stim_out), 32'h01);
      chk("rst_sig", 32'(signature), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);

      // single vector
      resp_in = 16'h00A5;
      do_start(16'd1);
      chk("v1_busy", 32'(busy), 32'h1);
      chk("v1_stim0", 32'(stim_out), 32'h01);
      wait_done(40, cyc);
      chk("v1_done", 32'(done), 32'h1);
      chk("v1_lat", 32'(cyc), 32'd3);
      chk("v1_sig", 32'(signature), 32'h00A5);
      tick();
      chk("v1_pulse", 32'(done), 32'h0);
      chk("v1_idle", 32'(busy), 32'h0);
      chk("v1_stim", 32'(stim_out), 32'h02);
      chk("v1_hold", 32'(signature), 32'h00A5);

      // two vectors, constant response
      resp_in = 16'h0001;
      do_start(16'd2);
      wait_done(40, cyc);
      chk("v2_lat", 32'(cyc), 32'd5);
      chk("v2_sig", 32'(signature), 32'h0003);
      tick();

      // nine vectors: stimulus walk, stray start mid-run
      do_start(16'd9);
      for (int c = 1; c <= 18; c++) begin
         chk("v9_walk", 32'(stim_out), 32'(walk[(c - 1) / 2]));
         start = (c == 5);
         if (c < 18) tick();
      end
      start = 1'b0;
      wait_done(40, cyc);
      chk("v9_done", 32'(done), 32'h1);
      chk("v9_stim", 32'(stim_out), 32'h3A);
      chk("v9_sig", 32'(signature), 32'h01FF);
      tick();
      chk("v9_pulse", 32'(done), 32'h0);

      // abort during the 3rd vector (WAIT phase, window c=5)
      do_start(16'd5);
      repeat (4) tick();
      chk("ab_pre", 32'(busy), 32'h1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy", 32'(busy), 32'h0);
      chk("ab_stim", 32'(stim_out), 32'h04);
      chk("ab_sig", 32'(signature), 32'h0003);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) pulses++;
         tick();
      end
      chk("ab_nodone", 32'(pulses), 32'd0);

      // zero-length run
      resp_in = 16'h00A5;
      do_start(16'd0);
      chk("z_done", 32'(done), 32'h1);
      chk("z_sig", 32'(signature), 32'h0);
      chk("z_busy", 32'(busy), 32'h0);
      tick();
      chk("z_pulse", 32'(done), 32'h0);

      // reset mid-run
      resp_in = 16'h0001;
      do_start(16'd5);
      repeat (4) tick();
      chk("mr_stim_pre", 32'(stim_out), 32'h04);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_stim", 32'(stim_out), 32'h01);
      chk("mr_sig", 32'(signature), 32'h0);
      chk("mr_busy", 32'(busy), 32'h0);
      chk("mr_done", 32'(done), 32'h0);

`ifdef GOLDEN_CHECK_EN
      resp_in = 16'h00A5;
      golden  = 16'h00A5;
      do_start(16'd1);
      wait_done(40, cyc);
      tick();
      chk("g_pass", 32'(pass), 32'h1);
      golden = 16'h00A4;
      do_start(16'd1);
      chk("g_clr", 32'(pass), 32'h0);
      wait_done(40, cyc);
      tick();
      chk("g_fail", 32'(pass), 32'h0);
      golden = 16'h0000;
      do_start(16'd0);
      chk("g_zero_done", 32'(done), 32'h1);
      tick();
      chk("g_zero_pass", 32'(pass), 32'h1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/io_bist_harness.md
# io_bist_harness

Parametrised on-chip stimulus/response harness for a hackathon_top-class user design. It lets the design be exercised without an external cocotb bench. An LFSR drives the DUT's input bus for a programmed number of vectors. After a settle delay per vector, it compacts the DUT's output bus into a MISR signature. The harness sits beside the user project in the top wrapper: stim_out feeds ui_in, and resp_in collects {uio_out, uo_out}.

## Interface
- DATA_W, 8, stimulus width (≥2)
- RESP_W, 16, response/signature width (≥2)
- CNT_W, 16, vector-counter width
- LFSR_TAPS, 8'h1D, Galois feedback mask for the stimulus LFSR, DATA_W bits
- MISR_TAPS, 16'h1021, Galois feedback mask for the MISR, RESP_W bits
- SEED, 8'h01, LFSR start value, nonzero
- SETTLE_CYC, 1, wait cycles between applying a vector and capturing its response (≥0)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  cancel the run in progress; no done
- vec_count  in  CNT_W  number of vectors; latched on start
- resp_in  in  RESP_W  DUT response bus
- stim_out  out  DATA_W  DUT stimulus (the LFSR register)
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- signature  out  RESP_W  MISR value; holds after done

## Operation
- States: IDLE, WAIT, CAPTURE, FINISH.
- Registers: lfsr, misr, remaining, settle counter.
- IDLE, start=1 and vec_count≠0:
  - lfsr←SEED, misr←0, remaining←vec_count, settle←SETTLE_CYC.
  - Next state is WAIT, or CAPTURE if SETTLE_CYC=0.
- IDLE, start=1 and vec_count=0:
  - misr←0, lfsr←SEED.
  - Go to FINISH.
- WAIT: settle counts down. Move to CAPTURE on the cycle it reaches 1.
- CAPTURE performs these updates:
  - misr←(misr<<1) ^ (misr[RESP_W-1] ? MISR_TAPS : 0) ^ resp_in.
  - lfsr←(lfsr<<1) ^ (lfsr[DATA_W-1] ? LFSR_TAPS : 0).
  - remaining←remaining−1.
- CAPTURE exit:
  - remaining=1 → FINISH.
  - Otherwise reload settle and go to WAIT, or stay in CAPTURE if SETTLE_CYC=0.
- FINISH: done=1 for one cycle, then IDLE.
- busy=1 exactly in WAIT and CAPTURE.
- start outside IDLE is ignored.
- abort in WAIT or CAPTURE: → IDLE next cycle. No done, misr/lfsr frozen at their current values. abort in IDLE or FINISH is ignored.
- abort and start are never both acted on: start is only seen in IDLE, where abort is ignored.
- rst has priority over everything. It can arrive mid-run.
- All arithmetic is modulo register width. The LFSR never reaches 0 from a nonzero seed with a primitive LFSR_TAPS.

## Timing
- Reset values: stim_out=SEED, signature=0, busy=0, done=0, state IDLE.
- Start is accepted at edge T0. busy=1 from T0+1. The new stim_out (SEED) is visible from T0+1.
- Each vector takes SETTLE_CYC+1 cycles. The stimulus is stable for the whole vector period and changes only on the CAPTURE edge.
- resp_in is sampled on the CAPTURE edge, SETTLE_CYC+1 edges after that vector was applied.
- done is asserted N·(SETTLE_CYC+1)+1 cycles after the start edge, for vec_count=N.
- For N=0, done asserts 1 cycle after the start edge.
- signature is final when done=1 and holds until the next accepted start.
- The earliest back-to-back start is the cycle after done.

## Configuration
- GOLDEN_CHECK_EN defined:
  - Adds input golden [RESP_W] and output pass [1].
  - On the FINISH transition, pass←(final misr == golden).
  - pass is cleared on reset and on start accept, and held otherwise.
  - An aborted run leaves pass=0.
- GOLDEN_CHECK_EN undefined: no golden or pass ports, and no comparator logic.

## Test plan
- Reset, then idle 5 cycles: check stim_out=8'h01, signature=0, busy=0, done=0.
- SETTLE_CYC=1, vec_count=1, resp_in=16'h00A5: check signature=16'h00A5, done pulses exactly 3 cycles after the start edge, stim_out=8'h02 after done.
- vec_count=2, resp_in=16'h0001 constant: check signature=16'h0003.
- vec_count=9: check stim_out walks 01,02,04,08,10,20,40,80,1D and is 8'h3A at done. Assert start mid-run: check it is ignored.
- Abort in the 3rd vector: check busy drops next cycle, no done pulse. Then rst mid-run: all reset values next cycle.
- GOLDEN_CHECK_EN, vec_count=1, resp_in=16'h00A5:
  - golden=16'h00A5 → pass=1.
  - Rerun with golden=16'h00A4 → pass=0.
  - vec_count=0 → done 1 cycle after start, signature=0.
